// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : FETCH (normal fetching) / STOPPED (end-of-program reached)
//   IFU_RESET_PC  : PC loaded at reset
//   IFU_STOP_INST : instruction word marking end of program
//   IFU_NOP_INST  : word driven on the IF/ID interface when nothing valid is presented
package inst_fetch_unit_pkg;

    typedef enum logic {
        FETCH   = 1'b0,
        STOPPED = 1'b1
    } fetch_state_e;

    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] IFU_STOP_INST = 32'h0000_0000;
    localparam logic [31:0] IFU_NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_unit_hold_buf.sv
// fetch_hold_buf: single-entry skid register for the fetch stage. It catches
// the memory response that arrives while downstream is stalled, because the
// synchronous memory only presents read data for one cycle.
//   clk, rstn   : clock, asynchronous active-low reset
//   load_i      : capture inst_i/pc_i and mark the entry valid
//   clear_i     : drop the entry (wins over load_i)
//   inst_i/pc_i : response word and its PC
//   valid_o, inst_o, pc_o : current entry
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch stage, producer side of the IF/ID register.
// Generates the PC, drives a 1-cycle-latency instruction memory and presents
// each fetched instruction with its PC. Honours stall (back-pressure), flush
// (redirect) and halts on the end-of-program word until flushed or reset.
//   clk, rstn        : clock, asynchronous active-low reset
//   stall_in         : downstream cannot accept this cycle
//   flush_in         : redirect to flush_pc_in
//   flush_pc_in      : redirect target (word aligned)
//   imem_ren_out     : memory read enable
//   imem_addr_out    : memory byte address
//   imem_rdata_in    : read data, valid the cycle after a read
//   inst_IF_out      : presented instruction (NOP when not valid)
//   pc_IF_out        : PC of the presented instruction
//   valid_IF_out     : inst_IF_out is a real instruction
//   stop_out         : end of program reached
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
    parameter logic [31:0] STOP_INST = IFU_STOP_INST,
    parameter logic [31:0] NOP_INST  = IFU_NOP_INST
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        imem_ren_out,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] inst_IF_out,
    output logic [31:0] pc_IF_out,
    output logic        valid_IF_out,
    output logic        stop_out
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;

    logic        hold_valid;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic        hold_load;
    logic        hold_clear;

    logic        deliver;
    logic        stop_hit;

    // ---------------------------------------------------------------
    // Presentation: the skid entry is older than the live memory
    // response, so it has priority. The two are never valid together.
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        valid_IF_out = (hold_valid | resp_valid_q) & (state_q == FETCH);
        inst_IF_out  = NOP_INST;
        pc_IF_out    = hold_valid ? hold_pc : resp_pc_q;
        if (valid_IF_out) begin
            inst_IF_out = hold_valid ? hold_inst : imem_rdata_in;
        end
    end

    assign deliver  = valid_IF_out & ~stall_in & ~flush_in;
    assign stop_hit = deliver & (inst_IF_out == STOP_INST);

    // ---------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = FETCH;
        end else if (stop_hit) begin
            state_d = STOPPED;
        end
    end

    // rstn gates the read enable so the memory sees no request during reset.
    always_comb begin
        imem_ren_out = rstn & (state_q == FETCH) & ~stall_in & ~flush_in & ~stop_hit;
        stop_out     = stop_hit | (state_q == STOPPED);
    end

    assign imem_addr_out = pc_q;

    // ---------------------------------------------------------------
    // PC and in-flight response tracking
    // ---------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = imem_ren_out;
        if (flush_in) begin
            pc_d = flush_pc_in;
        end else if (imem_ren_out) begin
            pc_d      = pc_q + 32'd4;
            resp_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            resp_pc_q    <= 32'h0;
            resp_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // The response lasts one cycle on the memory bus; park it if downstream
    // stalls. It leaves the skid on delivery, or is dropped by a flush.
    assign hold_load  = stall_in & resp_valid_q & ~hold_valid & ~flush_in;
    assign hold_clear = flush_in | (deliver & hold_valid);

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .inst_i  (imem_rdata_in),
        .pc_i    (resp_pc_q),
        .valid_o (hold_valid),
        .inst_o  (hold_inst),
        .pc_o    (hold_pc)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed walk through reset,
// stall, stop, flush and mid-stream reset, then randomized stall/flush
// traffic. A scoreboard of fetched-but-undelivered instructions predicts
// every cycle's outputs.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    localparam logic [31:0] STOP_W = IFU_STOP_INST;
    localparam logic [31:0] NOP_W  = IFU_NOP_INST;
    localparam logic [31:0] RST_PC = IFU_RESET_PC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc_in = 32'h0;
    logic        imem_ren_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in = 32'h0;
    logic [31:0] inst_IF_out;
    logic [31:0] pc_IF_out;
    logic        valid_IF_out;
    logic        stop_out;

    inst_fetch_unit dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall_in      (stall_in),
        .flush_in      (flush_in),
        .flush_pc_in   (flush_pc_in),
        .imem_ren_out  (imem_ren_out),
        .imem_addr_out (imem_addr_out),
        .imem_rdata_in (imem_rdata_in),
        .inst_IF_out   (inst_IF_out),
        .pc_IF_out     (pc_IF_out),
        .valid_IF_out  (valid_IF_out),
        .stop_out      (stop_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- program image ----------------
    logic [31:0] prog [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (prog.exists(a)) return prog[a];
        h = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
        h = h ^ (h >> 15);
        if (h[11:8] == 4'h0) return STOP_W;
        return h;
    endfunction

    // Synchronous-read memory; outside the response cycle the bus carries junk.
    always @(posedge clk) begin
        if (imem_ren_out) imem_rdata_in <= mem_word(imem_addr_out);
        else              imem_rdata_in <= $urandom;
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t       sbq[$];
    item_t       head;
    logic [31:0] m_req_pc = RST_PC;
    bit          m_stopped = 1'b0;
    bit          exp_valid, exp_deliver, exp_hit, exp_ren;
    int          n_deliv = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_ren",   imem_ren_out,  1'b0);
            check("rst_valid", valid_IF_out,  1'b0);
            check("rst_stop",  stop_out,      1'b0);
            check("rst_inst",  inst_IF_out,   NOP_W);
            check("rst_pc",    pc_IF_out,     32'h0);
            check("rst_addr",  imem_addr_out, RST_PC);
            sbq.delete();
            m_req_pc  = RST_PC;
            m_stopped = 1'b0;
        end else begin
            exp_valid = (sbq.size() != 0) && !m_stopped;
            head.pc   = 32'h0;
            head.inst = NOP_W;
            if (sbq.size() != 0) head = sbq[0];
            if (!flush_in) begin
                check("valid", valid_IF_out, exp_valid);
                if (exp_valid) begin
                    check("pc_IF", pc_IF_out, head.pc);
                    check("inst_IF", inst_IF_out, head.inst);
                end else begin
                    check("inst_nop", inst_IF_out, NOP_W);
                end
            end
            exp_deliver = exp_valid && !stall_in && !flush_in;
            exp_hit     = exp_deliver && (head.inst == STOP_W);
            exp_ren     = !m_stopped && !stall_in && !flush_in && !exp_hit;
            check("stop", stop_out, m_stopped || exp_hit);
            check("ren", imem_ren_out, exp_ren);
            if (exp_ren) check("addr", imem_addr_out, m_req_pc);

            if (exp_deliver) begin
                void'(sbq.pop_front());
                n_deliv++;
            end
            if (flush_in) begin
                sbq.delete();
                m_req_pc  = flush_pc_in;
                m_stopped = 1'b0;
            end else begin
                if (exp_hit) m_stopped = 1'b1;
                if (exp_ren) begin
                    sbq.push_back('{pc: m_req_pc, inst: mem_word(m_req_pc)});
                    m_req_pc = m_req_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a += 4) prog[a] = 32'h0000_0013 | (a << 12);
        prog[32'h0] = 32'h0050_0093;
        prog[32'h4] = 32'h00A0_0113;
        prog[32'h10] = STOP_W;

        // Reset, then plain fetch from RESET_PC.
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("d_c0_ren", imem_ren_out, 1'b1);
        check("d_c0_addr", imem_addr_out, 32'h0);
        tick(); @(negedge clk);
        check("d_c1_valid", valid_IF_out, 1'b1);
        check("d_c1_pc", pc_IF_out, 32'h0);
        check("d_c1_inst", inst_IF_out, 32'h0050_0093);
        tick(); @(negedge clk);
        check("d_c2_pc", pc_IF_out, 32'h4);
        check("d_c2_addr", imem_addr_out, 32'h8);

        // Stall three cycles with 0x8 in flight.
        tick(); stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            check("d_stall_pc", pc_IF_out, 32'h8);
            check("d_stall_ren", imem_ren_out, 1'b0);
            check("d_stall_addr", imem_addr_out, 32'hC);
        end
        tick(); stall_in = 1'b0;
        @(negedge clk);
        check("d_unstall_pc", pc_IF_out, 32'h8);
        check("d_unstall_ren", imem_ren_out, 1'b1);
        check("d_unstall_addr", imem_addr_out, 32'hC);
        tick(); @(negedge clk);
        check("d_nobubble_valid", valid_IF_out, 1'b1);
        check("d_nobubble_pc", pc_IF_out, 32'hC);

        // Stop word at 0x10.
        tick(); @(negedge clk);
        check("d_stop_pc", pc_IF_out, 32'h10);
        check("d_stop_hit", stop_out, 1'b1);
        check("d_stop_ren", imem_ren_out, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(); @(negedge clk);
            check("d_stopped_valid", valid_IF_out, 1'b0);
            check("d_stopped_stop", stop_out, 1'b1);
            check("d_stopped_ren", imem_ren_out, 1'b0);
        end

        // Flush while stopped, together with a stall.
        tick(); flush_in = 1'b1; flush_pc_in = 32'h14; stall_in = 1'b1;
        @(negedge clk);
        tick(); flush_in = 1'b0;
        @(negedge clk);
        check("d_unstop_stop", stop_out, 1'b0);
        check("d_unstop_valid", valid_IF_out, 1'b0);
        tick(); stall_in = 1'b0;
        @(negedge clk);
        check("d_resume_addr", imem_addr_out, 32'h14);
        check("d_resume_ren", imem_ren_out, 1'b1);

        // Flush to 0x40 while 0x14 is pending.
        tick(); flush_in = 1'b1; flush_pc_in = 32'h40;
        @(negedge clk);
        check("d_flush_ren", imem_ren_out, 1'b0);
        tick(); flush_in = 1'b0;
        @(negedge clk);
        check("d_flush_drop", valid_IF_out, 1'b0);
        check("d_flush_ren1", imem_ren_out, 1'b1);
        check("d_flush_addr", imem_addr_out, 32'h40);
        tick(); @(negedge clk);
        check("d_flush_pc", pc_IF_out, 32'h40);

        // Fill the skid, then flush with stall held.
        tick(); stall_in = 1'b1;
        @(negedge clk);
        tick(); @(negedge clk);
        check("d_skid_pc", pc_IF_out, 32'h44);
        tick(); flush_in = 1'b1; flush_pc_in = 32'h80;
        @(negedge clk);
        tick(); flush_in = 1'b0;
        @(negedge clk);
        check("d_skid_cleared", valid_IF_out, 1'b0);
        tick(); stall_in = 1'b0;
        @(negedge clk);
        check("d_skid_addr", imem_addr_out, 32'h80);
        tick(); @(negedge clk);
        check("d_skid_pc80", pc_IF_out, 32'h80);

        // Mid-stream reset with the skid full.
        tick(); stall_in = 1'b1;
        @(negedge clk);
        tick(); @(negedge clk);
        check("d_full_valid", valid_IF_out, 1'b1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("d_arst_valid", valid_IF_out, 1'b0);
        check("d_arst_ren", imem_ren_out, 1'b0);
        check("d_arst_inst", inst_IF_out, NOP_W);
        check("d_arst_pc", pc_IF_out, 32'h0);
        check("d_arst_addr", imem_addr_out, RST_PC);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1; stall_in = 1'b0;
        @(negedge clk);
        check("d_rel_addr", imem_addr_out, RST_PC);
        check("d_rel_ren", imem_ren_out, 1'b1);
        tick(); @(negedge clk);
        check("d_rel_inst", inst_IF_out, 32'h0050_0093);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            tick();
            stall_in = ($urandom % 100) < 30;
            flush_in = ($urandom % 100) < 4;
            if ($urandom % 8 == 0) flush_pc_in = 32'hFFFF_FFF0;
            else                   flush_pc_in = $urandom_range(0, 1023) << 2;
        end
        tick();
        stall_in = 1'b0;
        flush_in = 1'b0;
        @(negedge clk);
        check("deliveries_seen", 32'(n_deliv > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
